// File: rtl/dac_sample_sched_pkg.sv
// Shared definitions for the DAC sample scheduler.
//   sample_t : one 8-bit excess-128 audio sample (8'h80 is the zero level)
//   SILENCE  : sample presented when a channel has nothing to play or output is muted
//   mode_e   : output source selection driven from the CPU sound registers
//   mix_avg  : truncating average of two excess-128 samples
package dac_sample_sched_pkg;

  typedef logic [7:0] sample_t;

  localparam sample_t SILENCE = 8'h80;

  typedef enum logic [1:0] {
    MODE_MIX  = 2'b00,
    MODE_CH0  = 2'b01,
    MODE_CH1  = 2'b10,
    MODE_MUTE = 2'b11
  } mode_e;

  // Averaging two excess-128 values keeps the 128 bias intact, so the
  // result is still excess-128 and can go straight to the DAC.
  function automatic sample_t mix_avg(input sample_t a, input sample_t b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sample_t'(sum >> 1);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous first-word-fall-through FIFO for one audio channel.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write data_i this cycle (ignored when full)
//   pop_i        : discard the head entry this cycle (ignored when empty)
//   data_i       : sample to write
//   data_o       : head entry, valid whenever empty_o is low
//   full_o       : all 2**FIFO_AW slots occupied
//   empty_o      : no entries stored
module dac_sample_fifo
  import dac_sample_sched_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  sample_t data_i,
  output sample_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  sample_t            mem_q [DEPTH];
  sample_t            mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  // Flags come from the registered count only, so ready seen by the
  // producer never depends on a same-cycle pop.
  assign full_o  = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents are don't-care while empty, so they carry no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dac_sample_sched.sv
// Sample scheduler in front of the 8-bit sigma-delta audio DAC.
//   clk_i, rst_i            : clock (shared with the DAC), synchronous active-high reset
//   div_i                   : a sample tick every div_i+1 clocks
//   mode_i                  : 00 mix, 01 ch0 only, 10 ch1 only, 11 mute
//   chN_data/valid/ready    : per-channel valid/ready sample input into a 4-deep FIFO
//   clr_i                   : clears the sticky underrun flags
//   underrun_o              : bit n set when channel n was empty at a tick
//   tick_o                  : one-cycle pulse when a new sample appears on dac_data_o
//   dac_data_o              : registered excess-128 sample to the DAC
module dac_sample_sched
  import dac_sample_sched_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int FIFO_AW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       ch0_data_i,
  input  logic             ch0_valid_i,
  output logic             ch0_ready_o,
  input  logic [7:0]       ch1_data_i,
  input  logic             ch1_valid_i,
  output logic             ch1_ready_o,
  input  logic             clr_i,
  output logic [1:0]       underrun_o,
  output logic             tick_o,
  output logic [7:0]       dac_data_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             full0, full1;
  logic             empty0, empty1;
  sample_t          head0, head1;
  sample_t          src0, src1;
  sample_t          sample;
  sample_t          dac_data_q, dac_data_d;
  logic             tick_q, tick_d;
  logic [1:0]       underrun_q, underrun_d;

  assign ch0_ready_o = !full0;
  assign ch1_ready_o = !full1;

  // Both channels pop on every tick whatever the mode, so an unused
  // channel keeps draining and stays time-aligned with the other.
  dac_sample_fifo #(.FIFO_AW(FIFO_AW)) u_fifo0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ch0_valid_i && ch0_ready_o),
    .pop_i   (tick),
    .data_i  (ch0_data_i),
    .data_o  (head0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  dac_sample_fifo #(.FIFO_AW(FIFO_AW)) u_fifo1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ch1_valid_i && ch1_ready_o),
    .pop_i   (tick),
    .data_i  (ch1_data_i),
    .data_o  (head1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  // Divider: the counter is never clamped, so lowering div_i below the
  // current count simply lets it run round through all-ones to zero.
  always_comb begin
    tick  = (cnt_q == div_i);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Sample formation and flag update for the tick cycle; the result is
  // registered, so the DAC sees it one clock after the tick.
  always_comb begin
    src0       = empty0 ? SILENCE : head0;
    src1       = empty1 ? SILENCE : head1;
    sample     = SILENCE;
    dac_data_d = dac_data_q;
    tick_d     = tick;
    underrun_d = clr_i ? 2'b00 : underrun_q;

    case (mode_e'(mode_i))
      MODE_MIX:  sample = mix_avg(src0, src1);
      MODE_CH0:  sample = src0;
      MODE_CH1:  sample = src1;
      MODE_MUTE: sample = SILENCE;
    endcase

    // Applied after the clear so a new underrun wins over clr_i.
    if (tick) begin
      dac_data_d = sample;
      underrun_d = underrun_d | {empty1, empty0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      dac_data_q <= SILENCE;
      tick_q     <= 1'b0;
      underrun_q <= 2'b00;
    end else begin
      cnt_q      <= cnt_d;
      dac_data_q <= dac_data_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign dac_data_o = dac_data_q;
  assign tick_o     = tick_q;
  assign underrun_o = underrun_q;

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Sample scheduler feeding the 8-bit sigma-delta audio DAC. It buffers samples from two sources (ch0: cassette/tape echo, ch1: sound generator) in small FIFOs, each through a valid/ready handshake. It paces output with a programmable sample-rate divider and, on every sample tick, pops both channels and presents one mixed, selected or muted excess-128 byte to the DAC input. It sits between the CPU-side sound registers and the DAC, which it drives continuously.

## Interface
Parameters:
- DIV_W, 12: width of the sample-rate divider.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW (4) per channel.

Ports:
- clk_i, in, 1: system clock, the same clock as the DAC.
- rst_i, in, 1: reset, synchronous and active-high.
- div_i, in, DIV_W: a sample tick occurs every div_i+1 clocks.
- mode_i, in, 2: 00 mix, 01 ch0 only, 10 ch1 only, 11 mute.
- ch0_data_i, in, 8: ch0 sample, excess-128.
- ch0_valid_i, in, 1: ch0 sample offered.
- ch0_ready_o, out, 1: ch0 FIFO not full.
- ch1_data_i, ch1_valid_i, ch1_ready_o: same as ch0, for ch1.
- clr_i, in, 1: clears the sticky underrun flags.
- underrun_o, out, 2: sticky flag per channel; bit n is set when channel n's FIFO is empty at a tick.
- tick_o, out, 1: one-cycle pulse marking the cycle a new sample appears on dac_data_o.
- dac_data_o, out, 8: registered sample to the DAC input.

## Operation
- Divider: cnt counts 0..div_i.
  - tick is asserted when cnt == div_i; cnt then reloads 0.
  - div_i = 0 gives a tick every clock.
  - If div_i changes to a value below cnt, the next tick occurs at cnt == DIV_W'all-ones wrap. The counter is not clamped, so a div_i change mid-count needs no special handling beyond this wrap.
- Push: a sample is written when chN_valid_i && chN_ready_o. chN_ready_o = !full, derived combinationally from the registered count.
- Pop: on tick, both FIFOs pop if non-empty, regardless of mode. Mute and single-channel modes still drain the unused channel, which keeps the channels time-aligned.
- Empty at tick: that channel contributes 8'h80 (silence) and its underrun_o bit sets.
- Sample formation, using mode_i as sampled on the tick cycle:
  - mix: 9-bit sum a+b, output sum[8:1] (truncating average; excess-128 is preserved).
  - 01: a.
  - 10: b.
  - 11: 8'h80.
- Simultaneous events:
  - Push to a full FIFO cannot occur, because ready is low. A pop in the same cycle frees the slot, and ready rises the next cycle.
  - Push and pop on an empty FIFO in the same cycle: the pop sees empty (silence plus underrun), and the pushed sample is stored for the next tick.
  - Push and pop on a partially filled FIFO in the same cycle: the count is unchanged.
  - clr_i coinciding with a new underrun: set wins.
- Reset values: dac_data_o = 8'h80, tick_o = 0, underrun_o = 0, FIFOs empty, chN_ready_o = 1, cnt = 0.
- Reset mid-operation discards all buffered samples and the partial divider count. The first tick after reset release falls div_i+1 clocks later.

## Timing
- dac_data_o and tick_o update on the clock edge following the tick cycle, giving a latency of 1 clock from tick to output.
- The output holds constant between ticks.
- Push-to-output latency is at least 1 tick boundary. A sample pushed in cycle t is eligible for a tick in cycle t+1 or later.
- Ready lags the pop by 1 clock.
- underrun_o sets in the same edge that updates dac_data_o.
- FIFO read data is combinational from the registered storage (first-word fall-through), so the mixer operates within the tick cycle.

## Structure
- The shared package holds:
  - SILENCE = 8'h80
  - mode encodings MODE_MIX, MODE_CH0, MODE_CH1, MODE_MUTE
  - sample type as 8-bit excess-128
- Sub-module dac_sample_fifo:
  - synchronous FWFT FIFO parameterised by FIFO_AW
  - ports: push, pop, data in/out, full, empty
  - instantiated twice
- The divider, mixer, flags and output register live in the top module.

## Test plan
- Reset with div_i = 3 and both FIFOs empty:
  - dac_data_o stays 8'h80.
  - tick_o pulses every 4 clocks.
  - underrun_o = 2'b11 after the first tick.
  - clr_i clears the flags, which set again at the next tick.
- Mix mode, ch0 = 8'hFF, ch1 = 8'h81 preloaded, div_i = 0: dac_data_o = 8'hC0 one clock after the tick; the next tick outputs 8'h80 with underrun.
- Backpressure: push 5 samples to ch0 with no tick (div_i = 12'hFFF). ch0_ready_o drops after the 4th sample. A tick frees one slot, and ready rises 1 clock later.
- Mode 10 with ch0 = 8'h10 and ch1 = 8'hF0 queued:
  - output is 8'hF0
  - both FIFOs drop by one
  - mode 11 outputs 8'h80 and still pops both.
- Push into an empty ch1 on the exact tick cycle: that tick outputs silence and sets underrun_o[1]. The next tick outputs the pushed value.
- rst_i asserted with 3 samples queued and cnt mid-count:
  - FIFOs empty
  - dac_data_o = 8'h80
  - the next tick occurs div_i+1 clocks after release.
